mdu_sequencer: RTL
==================

// Module: mdu_sequencer
// PURPOSE
//   Sequences the multiply/divide unit of the pipelined MIPS core: accepts one MD op from the E stage,
//   runs it for a fixed cycle count, and commits the result to the HI/LO registers.
//   Raises a stall to the hazard logic whenever a D-stage instruction touches HI/LO while an op is pending.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for MULT/MULTU (and MADD/MSUB); legal range 1..15
//   DIV_CYCLES   10  busy cycles for DIV/DIVU; legal range 1..15
// PORTS
//   clk        in   1   clock; all state changes on the rising edge
//   reset      in   1   asynchronous, active-high; clears all state
//   start      in   1   E stage holds a valid MD op this cycle
//   md_op      in   4   op code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MSUB
//   rs_val     in   32  forwarded rs operand (dividend / multiplicand / MTHI-MTLO source)
//   rt_val     in   32  forwarded rt operand
//   md_use_d   in   1   D-stage instruction is MULT/DIV/MTHI/MTLO/MFHI/MFLO/MADD/MSUB
//   busy       out  1   an op is in flight
//   stall      out  1   = md_use_d & (busy | (start & md_op in 1..4,7,8)); combinational
//   hi         out  32  HI register
//   lo         out  32  LO register
// BEHAVIOUR
//   - Reset (any time, including mid-op): state=IDLE, counter=0, busy=0, hi=0, lo=0, pending result discarded.
//   - FSM states: IDLE, RUN. The counter is 4 bits wide.
//   - IDLE -> RUN: at an edge with start=1 and md_op in {1,2,3,4,7,8}.
//     On that edge, operands are latched, the 64-bit result is computed, and the counter is loaded with
//     MULT_CYCLES-1 (mult class) or DIV_CYCLES-1 (div class).
//   - RUN: busy=1. The counter decrements each edge. At the edge where counter==0, {hi,lo} takes the
//     latched result and state returns to IDLE.
//     busy is therefore high for exactly N cycles; the new hi/lo value is visible on the first cycle busy=0.
//   - MTHI/MTLO (5/6) in IDLE: hi (or lo) <= rs_val at the same edge; busy stays 0; no stall generated.
//   - start while RUN: ignored entirely, whatever md_op is. The pipeline stall guarantees this cannot occur legally.
//   - md_op 0 or any undefined code: no effect.
//   - MULT: signed 32x32 -> 64 product; {hi,lo}=product. MULTU: the same, unsigned.
//   - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend (DIV).
//   - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
//   - Divisor 0 (DIV or DIVU): full DIV_CYCLES busy period, then hi/lo are left unchanged.
//   - stall covers the same cycle a MD op enters E, so a D-stage MFHI/MFLO behind it never reads stale HI/LO.
// CONFIGURATION
//   MDU_MADD_EN defined:
//     MADD (7): {hi,lo} <= {hi,lo} + signed(rs*rt).
//     MSUB (8): {hi,lo} <= {hi,lo} - signed(rs*rt).
//     Both use MULT_CYCLES. The accumulate uses the hi/lo value present at commit time.
//   MDU_MADD_EN undefined: codes 7/8 are treated as NONE; they start no op and produce no stall term.
// STRUCTURE
//   - Shared package mdu_pkg holds:
//     - md_op localparams (OP_NONE..OP_MSUB)
//     - state encoding (ST_IDLE, ST_RUN)
//     - the 4-bit counter width constant
//   - One sub-module, mdu_result_calc: combinational; inputs op, rs, rt, hi, lo; outputs the 64-bit result
//     and a div_by_zero flag.
//   - mdu_sequencer owns the FSM, counter, operand/result latches, HI/LO and stall logic.
// TESTING
//   1. MULT rs=0xFFFFFFFF rt=2
//      -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//   2. DIVU rs=7 rt=2, md_use_d=1 throughout
//      -> stall=1 on the start cycle plus all 10 busy cycles; then lo=3, hi=1; stall=0 afterwards.
//   3. DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//      Then DIV rt=0 -> 10 busy cycles, hi/lo unchanged.
//   4. MULTU 0x10000*0x10000, reset pulsed on busy cycle 3
//      -> busy=0, hi=lo=0 immediately (asynchronous); no late commit after reset is released.
//   5. MTHI rs=0x1234 in IDLE -> hi=0x1234 next cycle, busy stays 0.
//      MTLO issued during a MULT -> ignored; lo = product only.
//   6. With MDU_MADD_EN defined: hi=0, lo=5, then MADD rs=3 rt=4 -> lo=17 after 5 cycles.
//      Without the macro, the same stimulus leaves lo=5 and busy=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, state encoding and counter width for the MD unit sequencer
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;

  localparam int CNT_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// rtl/mdu_sequencer_if.sv - E/D-stage request and HI/LO result bundle of the MD unit
interface mdu_sequencer_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_d;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, rs_val, rt_val, md_use_d,
                  input  busy, stall, hi, lo);
  modport slave  (input  start, md_op, rs_val, rt_val, md_use_d,
                  output busy, stall, hi, lo);
endinterface

// File: rtl/mdu_result_calc.sv
// rtl/mdu_result_calc.sv - combinational 64-bit MULT/DIV/MADD/MSUB result and divide-by-zero flag
module mdu_result_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [63:0] result_o,
  output logic        div_by_zero_o
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic [63:0] acc;
  logic [31:0] rs_mag, rt_mag, dvd, dvs, dvs_safe, uq, ur;
  logic        signed_div;

  assign sprod = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
  assign uprod = {32'd0, rs_i} * {32'd0, rt_i};
  assign acc   = {hi_i, lo_i};

  // One unsigned divider serves both forms; DIV works on magnitudes and fixes signs afterwards.
  assign signed_div = (op_i == OP_DIV);
  assign rs_mag     = rs_i[31] ? -rs_i : rs_i;
  assign rt_mag     = rt_i[31] ? -rt_i : rt_i;
  assign dvd        = signed_div ? rs_mag : rs_i;
  assign dvs        = signed_div ? rt_mag : rt_i;
  assign dvs_safe   = (dvs == 32'd0) ? 32'd1 : dvs;
  assign uq         = dvd / dvs_safe;
  assign ur         = dvd % dvs_safe;

  assign div_by_zero_o = is_div_op(op_i) && (rt_i == 32'd0);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_MULT:  result_o = sprod;
      OP_MULTU: result_o = uprod;
      OP_DIV:   result_o = {(rs_i[31] ? -ur : ur), ((rs_i[31] ^ rt_i[31]) ? -uq : uq)};
      OP_DIVU:  result_o = {ur, uq};
      OP_MADD:  result_o = acc + sprod;
      OP_MSUB:  result_o = acc - sprod;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - MD unit FSM, cycle counter, HI/LO and hazard stall; MDU_MADD_EN enables MADD/MSUB
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  mdu_sequencer_if.slave   md
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [31:0]       rs_q, rs_d, rt_q, rt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [63:0]       result;
  logic              div_by_zero;
  logic              md_start;
  logic              busy;

  function automatic logic starts_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= OP_MULT && op <= OP_DIVU) || op == OP_MADD || op == OP_MSUB;
`else
    return (op >= OP_MULT && op <= OP_DIVU);
`endif
  endfunction

  // HI/LO are frozen while RUN, so evaluating from current hi/lo at commit is the accumulate source.
  mdu_result_calc u_calc (
    .op_i          (op_q),
    .rs_i          (rs_q),
    .rt_i          (rt_q),
    .hi_i          (hi_q),
    .lo_i          (lo_q),
    .result_o      (result),
    .div_by_zero_o (div_by_zero)
  );

  assign md_start = md.start && starts_op(md.md_op);
  assign busy     = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md_start) begin
          state_d = ST_RUN;
          op_d    = md.md_op;
          rs_d    = md.rs_val;
          rt_d    = md.rt_val;
          cnt_d   = is_div_op(md.md_op) ? DIV_LOAD : MULT_LOAD;
        end else if (md.start && md.md_op == OP_MTHI) begin
          hi_d = md.rs_val;
        end else if (md.start && md.md_op == OP_MTLO) begin
          lo_d = md.rs_val;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (!div_by_zero) begin
            {hi_d, lo_d} = result;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      rs_q    <= '0;
      rt_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.busy  = busy;
  assign md.stall = md.md_use_d && (busy || md_start);
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;

endmodule
